// File: rtl/prg_load_sequencer.sv
// Streams PRG/CRT download bytes into the external memory port, then patches the BASIC end pointers.
// One write outstanding at a time; bytes arriving while a write waits for mem_ack are dropped and flagged.
module prg_load_sequencer #(
  parameter logic [15:0] CART_ADDR  = 16'hA000,
  parameter int          RESET_HOLD = 4
) (
  input  logic        i_clk_sys,
  input  logic        i_reset,
  input  logic        i_dl_active,
  input  logic        i_dl_wr,
  input  logic [15:0] i_dl_addr,
  input  logic [7:0]  i_dl_data,
  input  logic        i_raw_mode,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_data,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_force_reset,
  output logic [15:0] o_end_addr
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LWAIT, S_INJ, S_RST} state_t;

  state_t      r_state;
  logic [15:0] r_ptr;
  logic        r_req;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic        r_overrun;
  logic        r_force;
  logic        r_auto;
  logic        r_wrote;
  logic [2:0]  r_inj_idx;
  logic [7:0]  r_rst_cnt;

  logic        w_hdr_lo;
  logic        w_hdr_hi;
  logic        w_raw_first;
  logic [15:0] w_wr_addr;
  logic [7:0]  w_inj_base;
  logic [15:0] w_inj_addr;
  logic [7:0]  w_inj_data;

  assign w_hdr_lo    = !i_raw_mode && (i_dl_addr == 16'd0);
  assign w_hdr_hi    = !i_raw_mode && (i_dl_addr == 16'd1);
  assign w_raw_first =  i_raw_mode && (i_dl_addr == 16'd0);
  assign w_wr_addr   = w_raw_first ? CART_ADDR : r_ptr;

  // Pointer pairs live at $2D/$2F/$31 (lo, hi) and $AE/$AF.
  always_comb begin
    w_inj_base = 8'hAE;
    case (r_inj_idx[2:1])
      2'd0:    w_inj_base = 8'h2D;
      2'd1:    w_inj_base = 8'h2F;
      2'd2:    w_inj_base = 8'h31;
      default: w_inj_base = 8'hAE;
    endcase
  end

  assign w_inj_addr = {8'h00, w_inj_base + {7'd0, r_inj_idx[0]}};
  assign w_inj_data = r_inj_idx[0] ? r_ptr[15:8] : r_ptr[7:0];

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 16'd0;
      r_req     <= 1'b0;
      r_addr    <= 16'd0;
      r_data    <= 8'd0;
      r_overrun <= 1'b0;
      r_force   <= 1'b0;
      r_auto    <= 1'b0;
      r_wrote   <= 1'b0;
      r_inj_idx <= 3'd0;
      r_rst_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_dl_active) begin
            r_state   <= S_LOAD;
            r_overrun <= 1'b0;
            r_wrote   <= 1'b0;
            r_auto    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!i_dl_active) begin
            r_inj_idx <= 3'd0;
            r_state   <= r_wrote ? S_INJ : S_IDLE;
          end else if (i_dl_wr) begin
            if (w_hdr_lo) begin
              r_ptr[7:0] <= i_dl_data;
            end else if (w_hdr_hi) begin
              r_ptr[15:8] <= i_dl_data;
            end else begin
              r_req   <= 1'b1;
              r_addr  <= w_wr_addr;
              r_data  <= i_dl_data;
              r_state <= S_LWAIT;
              if (w_raw_first) r_ptr <= CART_ADDR;
              if (!r_wrote && (w_wr_addr == CART_ADDR)) r_auto <= 1'b1;
            end
          end
        end
        S_LWAIT: begin
          if (i_dl_wr) r_overrun <= 1'b1;
          if (i_mem_ack) begin
            r_req   <= 1'b0;
            r_ptr   <= r_ptr + 16'd1;
            r_wrote <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_INJ: begin
          // Issuing only while req is low guarantees an idle cycle between writes.
          if (!r_req) begin
            r_req  <= 1'b1;
            r_addr <= w_inj_addr;
            r_data <= w_inj_data;
          end else if (i_mem_ack) begin
            r_req     <= 1'b0;
            r_inj_idx <= r_inj_idx + 3'd1;
            if (r_inj_idx == 3'd7) begin
              if (r_auto) begin
                r_state   <= S_RST;
                r_force   <= 1'b1;
                r_rst_cnt <= 8'(RESET_HOLD - 1);
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_RST: begin
          if (r_rst_cnt == 8'd0) begin
            r_force <= 1'b0;
            r_auto  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rst_cnt <= r_rst_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req     = r_req;
  assign o_mem_addr    = r_addr;
  assign o_mem_data    = r_data;
  assign o_busy        = (r_state != S_IDLE);
  assign o_overrun     = r_overrun;
  assign o_force_reset = r_force;
  assign o_end_addr    = r_ptr;

endmodule

// File: tb/tb_prg_load_sequencer.sv
// Directed bench: a memory responder with programmable ack delay logs writes; the main sequence checks them.
module tb_prg_load_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        raw_mode;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        busy;
  logic        overrun;
  logic        force_reset;
  logic [15:0] end_addr;

  int checks = 0;
  int errors = 0;
  int ack_delay = 1;
  int wait_cnt = 0;
  int force_cnt = 0;
  int rise_cnt = 0;
  logic prev_req = 1'b0;
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  logic [7:0]  inj_base[8];
  int wb, fb, rb;

  always #5 clk = ~clk;

  prg_load_sequencer #(.CART_ADDR(16'hA000), .RESET_HOLD(4)) dut (
    .i_clk_sys(clk), .i_reset(reset), .i_dl_active(dl_active), .i_dl_wr(dl_wr),
    .i_dl_addr(dl_addr), .i_dl_data(dl_data), .i_raw_mode(raw_mode),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_data(mem_data), .i_mem_ack(mem_ack),
    .o_busy(busy), .o_overrun(overrun), .o_force_reset(force_reset), .o_end_addr(end_addr)
  );

  // Memory responder and activity monitor.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (force_reset) force_cnt++;
      if (mem_req && !prev_req) rise_cnt++;
      prev_req = mem_req;
      if (reset) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          wq_addr.push_back(mem_addr);
          wq_data.push_back(mem_data);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},     32'(mem_req), 32'h0);
    check({tag, "_addr"},    32'(mem_addr), 32'h0);
    check({tag, "_data"},    32'(mem_data), 32'h0);
    check({tag, "_busy"},    32'(busy), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_force"},   32'(force_reset), 32'h0);
    check({tag, "_end"},     32'(end_addr), 32'h0);
  endtask

  task automatic expect_wr(input int idx, input logic [15:0] a, input logic [7:0] d);
    if (idx < wq_addr.size()) begin
      check($sformatf("wr%0d_addr", idx), 32'(wq_addr[idx]), 32'(a));
      check($sformatf("wr%0d_data", idx), 32'(wq_data[idx]), 32'(d));
    end else begin
      check($sformatf("wr%0d_present", idx), 32'(wq_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic expect_inj(input int base, input logic [15:0] p);
    for (int k = 0; k < 8; k++)
      expect_wr(base + k, {8'h00, inj_base[k]}, (k % 2 == 1) ? p[15:8] : p[7:0]);
  endtask

  task automatic send(input logic [15:0] off, input logic [7:0] d);
    @(negedge clk);
    dl_wr = 1'b1; dl_addr = off; dl_data = d;
    @(negedge clk);
    dl_wr = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!mem_req) break;
      @(negedge clk);
    end
    check("send_req_drop", 32'(mem_req), 32'h0);
    @(negedge clk);
  endtask

  task automatic start_dl();
    @(negedge clk);
    dl_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  task automatic end_dl(input string tag);
    @(negedge clk);
    dl_active = 1'b0;
    wait_idle(tag);
  endtask

  task automatic mark();
    wb = wq_addr.size(); fb = force_cnt; rb = rise_cnt;
  endtask

  initial begin
    inj_base = '{8'h2D, 8'h2E, 8'h2F, 8'h30, 8'h31, 8'h32, 8'hAE, 8'hAF};
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 16'h0; dl_data = 8'h0; raw_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    // Header PRG at $1001, 1-cycle ack latency.
    mark(); ack_delay = 1;
    start_dl();
    check("t1_busy", 32'(busy), 32'h1);
    send(16'd0, 8'h01); send(16'd1, 8'h10);
    send(16'd2, 8'hAA); send(16'd3, 8'hBB); send(16'd4, 8'hCC);
    end_dl("t1_idle");
    expect_wr(wb + 0, 16'h1001, 8'hAA);
    expect_wr(wb + 1, 16'h1002, 8'hBB);
    expect_wr(wb + 2, 16'h1003, 8'hCC);
    expect_inj(wb + 3, 16'h1004);
    check("t1_nwrites", 32'(wq_addr.size() - wb), 32'd11);
    check("t1_rises", 32'(rise_cnt - rb), 32'd11);
    check("t1_force", 32'(force_cnt - fb), 32'd0);
    check("t1_end", 32'(end_addr), 32'h1004);

    // Raw cartridge at CART_ADDR arms the reset pulse.
    mark(); raw_mode = 1'b1;
    start_dl();
    send(16'd0, 8'h11); send(16'd1, 8'h22); send(16'd2, 8'h33);
    end_dl("t2_idle");
    raw_mode = 1'b0;
    expect_wr(wb + 0, 16'hA000, 8'h11);
    expect_wr(wb + 1, 16'hA001, 8'h22);
    expect_wr(wb + 2, 16'hA002, 8'h33);
    expect_inj(wb + 3, 16'hA003);
    check("t2_force_width", 32'(force_cnt - fb), 32'd4);
    check("t2_end", 32'(end_addr), 32'hA003);

    // Slow ack with a second byte arriving while the first is pending.
    mark(); ack_delay = 5;
    start_dl();
    send(16'd0, 8'h00); send(16'd1, 8'hA0);
    @(negedge clk); dl_wr = 1'b1; dl_addr = 16'd2; dl_data = 8'h5A;
    @(negedge clk); dl_wr = 1'b0;
    check("t3_req_pending", 32'(mem_req), 32'h1);
    @(negedge clk); dl_wr = 1'b1; dl_addr = 16'd3; dl_data = 8'h6B;
    @(negedge clk); dl_wr = 1'b0;
    check("t3_overrun", 32'(overrun), 32'h1);
    for (int i = 0; i < 50; i++) begin
      if (!mem_req) break;
      @(negedge clk);
    end
    end_dl("t3_idle");
    expect_wr(wb + 0, 16'hA000, 8'h5A);
    expect_inj(wb + 1, 16'hA001);
    check("t3_nwrites", 32'(wq_addr.size() - wb), 32'd9);
    check("t3_force_width", 32'(force_cnt - fb), 32'd4);
    check("t3_overrun_sticky", 32'(overrun), 32'h1);
    check("t3_end", 32'(end_addr), 32'hA001);

    // Pointer wrap at $FFFF with same-cycle acks.
    mark(); ack_delay = 0;
    start_dl();
    check("t4_overrun_clr", 32'(overrun), 32'h0);
    send(16'd0, 8'hFF); send(16'd1, 8'hFF);
    send(16'd2, 8'h01); send(16'd3, 8'h02);
    end_dl("t4_idle");
    expect_wr(wb + 0, 16'hFFFF, 8'h01);
    expect_wr(wb + 1, 16'h0000, 8'h02);
    expect_inj(wb + 2, 16'h0001);
    check("t4_end", 32'(end_addr), 32'h0001);
    check("t4_force", 32'(force_cnt - fb), 32'd0);

    // Header-only file: no memory traffic.
    mark(); ack_delay = 1;
    start_dl();
    send(16'd0, 8'h34); send(16'd1, 8'h12);
    end_dl("t5_idle");
    check("t5_nwrites", 32'(wq_addr.size() - wb), 32'd0);
    check("t5_rises", 32'(rise_cnt - rb), 32'd0);
    check("t5_end", 32'(end_addr), 32'h1234);

    // Reset while injecting, with the 5th write request outstanding.
    mark(); ack_delay = 3;
    start_dl();
    send(16'd0, 8'h00); send(16'd1, 8'h20); send(16'd2, 8'h77);
    @(negedge clk); dl_active = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wq_addr.size() >= wb + 4) break;
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      if (mem_req) break;
      @(negedge clk);
    end
    check("t6_req_before_reset", 32'(mem_req), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("t6_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_nwrites", 32'(wq_addr.size() - wb), 32'd4);
    expect_wr(wb + 0, 16'h2000, 8'h77);
    expect_wr(wb + 1, 16'h002D, 8'h01);
    expect_wr(wb + 2, 16'h002E, 8'h20);
    expect_wr(wb + 3, 16'h002F, 8'h01);
    check("t6_force", 32'(force_cnt - fb), 32'd0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_req", 32'(mem_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
